mmio_io_bank: RTL and testbench
===============================

Name: mmio_io_bank

Overview:
- Parametrised, ring-attached MMIO endpoint for FPGA tiles. It replaces fixed board-specific I/O register logic with a generic bank of NUM_OUT output registers, NUM_IN conditioned input words, and sticky rising-edge capture with a maskable interrupt.
- Sits behind rc on the F2C port: consumes F2C requests, returns F2C responses.
- Drives and samples board pins (switches, buttons, LEDs, Arduino IO) through flat vectors.

Parameters:
- NUM_IN, 2, number of 32-bit input words; legal range 1..64
- NUM_OUT, 8, number of 32-bit output registers; legal range 1..64
- SYNC_STAGES, 2, synchroniser depth on InPins; legal range ≥2
- DEBOUNCE_CYCLES, 16, QClk cycles a synced input word must be stable before it is accepted; legal range ≥1
- UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned for an unmapped address

Ports:
- QClk  in  1  core clock
- RstQnnnH  in  1  asynchronous active-high reset
- F2C_ReqValidQ502H  in  1  request valid from rc
- F2C_ReqOpcodeQ502H  in  t_opcode  RD or WR
- F2C_ReqAddressQ502H  in  32  byte address; only [11:2] decoded
- F2C_ReqDataQ502H  in  32  write data
- F2C_RspValidQ500H  out  1  response valid to rc
- F2C_RspOpcodeQ500H  out  t_opcode  RD_RSP or WR_RSP
- F2C_RspAddressQ500H  out  32  echoed request address
- F2C_RspDataQ500H  out  32  read data (RD_RSP), echoed write data (WR_RSP)
- InPins  in  32*NUM_IN  asynchronous board inputs; word i = bits [32i+31:32i]
- OutRegs  out  32*NUM_OUT  output register contents
- IrqPending  out  1  OR over all (EDGE[i] & MASK[i])

Behaviour:
- Clock and reset: one clock, QClk. Reset RstQnnnH is asynchronous and active-high.
- Reset values: every register, synchroniser stage, debounce counter, stable word, OUT, EDGE, MASK and response field clears to 0. Reset mid-operation discards any in-flight response and any debounce progress.
- Register map, word offset = Address[11:2]:
  - 0x000+4i: OUT[i], RW
  - 0x400+4i: IN[i], RO (debounced value)
  - 0x600+4i: EDGE[i], W1C
  - 0x700+4i: MASK[i], RW
  - Everything else is unmapped. Index i ≥ NUM_OUT or NUM_IN is unmapped.
- Request handling: no backpressure; one request is accepted every cycle F2C_ReqValidQ502H=1.
- Response latency: exactly 1 cycle.
  - Request in cycle N → F2C_RspValidQ500H=1 in cycle N+1.
  - Response carries RD→RD_RSP or WR→WR_RSP, the echoed address, and the read data or echoed write data.
  - Back-to-back requests give back-to-back responses.
- Any other opcode: no state change, no response.
- Reads: return the register value as of the request cycle, before any same-cycle update.
  - Writes to RO or unmapped addresses are dropped but still return WR_RSP.
  - Unmapped reads return UNMAPPED_DATA.
- Writes take effect at the end of the request cycle, so a read in the next cycle sees the new value.
- Input path, per word:
  - SYNC_STAGES flop synchroniser, then a debounce counter.
  - If the synced word differs from its previous-cycle value, the counter resets to 0. Otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES, IN[i] loads the synced word.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge capture: EDGE[i][b] sets when IN[i][b] transitions 0→1.
  - A write of 1 clears a bit; a write of 0 leaves it unchanged.
  - Set and clear in the same cycle: set wins.
- IrqPending is combinational from registered EDGE and MASK only (no path from request inputs).

Decomposition:
- lotr_pkg gains:
  - MMIO_OUT_BASE=10'h000, MMIO_IN_BASE=10'h100, MMIO_EDGE_BASE=10'h180, MMIO_MASK_BASE=10'h1C0 (word offsets)
  - UNMAPPED_DATA default value
- Opcodes RD/WR/RD_RSP/WR_RSP come from the existing t_opcode.
- Sub-module mmio_in_cond, instantiated NUM_IN times: synchroniser, debounce counter and edge detect for one 32-bit word. Outputs: stable word and a 32-bit rise pulse.

Test Plan:
- Reset, then RD 0x000, 0x400, 0x600, 0x700 → each returns RD_RSP data 0 one cycle later. OutRegs=0 and IrqPending=0.
- WR 0x004 data 32'hA5A5_0F0F, next cycle RD 0x004 → WR_RSP echoing the data, then RD_RSP 32'hA5A5_0F0F. OutRegs[63:32]=32'hA5A5_0F0F.
- InPins word0 goes 0→1 and held, DEBOUNCE_CYCLES=16 → IN[0] reads 1 only after SYNC_STAGES+16 cycles. A 5-cycle glitch to 1 → IN[0] stays 0.
- After IN[0][3] rises: EDGE[0]=8, and IrqPending=1 once MASK[0]=8 is written. WR 0x600 data 8 → EDGE[0]=0, IrqPending=0. A new rise coinciding with the W1C write → EDGE bit stays set.
- RD 0x7FC with NUM_OUT=8 → RD_RSP data 32'hDEAD_BEEF. WR 0x400 → WR_RSP, IN[0] unchanged.
- Four consecutive valid requests → four consecutive responses in order with correct addresses. Assert RstQnnnH mid-burst → F2C_RspValidQ500H drops immediately and all registers read 0 after release.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared ring opcode type plus the MMIO I/O bank word map.
// Latency: none (types, constants and a decode helper only).
// Backpressure: n/a.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    // Word offsets, i.e. byte address [11:2]
    localparam logic [9:0]  MMIO_OUT_BASE      = 10'h000;
    localparam logic [9:0]  MMIO_IN_BASE       = 10'h100;
    localparam logic [9:0]  MMIO_EDGE_BASE     = 10'h180;
    localparam logic [9:0]  MMIO_MASK_BASE     = 10'h1C0;
    localparam logic [31:0] MMIO_UNMAPPED_DATA = 32'hDEAD_BEEF;

    function automatic logic mmio_hit(input logic [9:0] word, input logic [9:0] base, input int idx);
        return word == 10'(int'(base) + idx);
    endfunction

endpackage

// File: rtl/mmio_in_cond.sv
// Conditions one 32-bit board input word: synchroniser, whole-word debounce, rise detect.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles from pin change to stable_word.
// Backpressure: none; free-running every cycle.
module mmio_in_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [31:0] pin_word,
    output logic [31:0] stable_word,
    output logic [31:0] rise
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [31:0]   sync_q [SYNC_STAGES];
    logic [31:0]   synced;
    logic [31:0]   prev_q;
    logic [31:0]   stable_q;
    logic [CW-1:0] cnt_q;
    logic          load;

    assign synced = sync_q[SYNC_STAGES-1];

    // Only accept when the word is still unchanged this cycle, so a change
    // arriving exactly at saturation can never be loaded unfiltered.
    assign load = (cnt_q == CNT_MAX) && (synced == prev_q);

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pin_word;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= synced;
            if (synced != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
        end else if (load) begin
            stable_q <= synced;
        end
    end

    assign rise        = load ? (synced & ~stable_q) : '0;
    assign stable_word = stable_q;

endmodule

// File: rtl/mmio_io_bank.sv
// Ring-attached MMIO bank: output registers, debounced inputs, sticky edge capture with mask/IRQ.
// Latency: every RD/WR request answers exactly one cycle later; writes land at end of request cycle.
// Backpressure: none; a request is accepted every valid cycle.
module mmio_io_bank
    import lotr_pkg::*;
#(
    parameter int          NUM_IN          = 2,
    parameter int          NUM_OUT         = 8,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] UNMAPPED_DATA   = MMIO_UNMAPPED_DATA
) (
    input  logic                    QClk,
    input  logic                    RstQnnnH,
    input  logic                    F2C_ReqValidQ502H,
    input  t_opcode                 F2C_ReqOpcodeQ502H,
    input  logic [31:0]             F2C_ReqAddressQ502H,
    input  logic [31:0]             F2C_ReqDataQ502H,
    output logic                    F2C_RspValidQ500H,
    output t_opcode                 F2C_RspOpcodeQ500H,
    output logic [31:0]             F2C_RspAddressQ500H,
    output logic [31:0]             F2C_RspDataQ500H,
    input  logic [32*NUM_IN-1:0]    InPins,
    output logic [32*NUM_OUT-1:0]   OutRegs,
    output logic                    IrqPending
);

    logic [9:0]  req_word;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] rd_data;

    logic [31:0] out_q     [NUM_OUT];
    logic [31:0] edge_q    [NUM_IN];
    logic [31:0] mask_q    [NUM_IN];
    logic [31:0] in_stable [NUM_IN];
    logic [31:0] in_rise   [NUM_IN];

    logic        rsp_vld_q;
    t_opcode     rsp_op_q;
    logic [31:0] rsp_addr_q;
    logic [31:0] rsp_data_q;
    logic        irq_any;

    assign req_word = F2C_ReqAddressQ502H[11:2];
    assign req_rd   = F2C_ReqValidQ502H && (F2C_ReqOpcodeQ502H == RD);
    assign req_wr   = F2C_ReqValidQ502H && (F2C_ReqOpcodeQ502H == WR);

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        mmio_in_cond #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .core_clk    (QClk),
            .rst         (RstQnnnH),
            .pin_word    (InPins[32*g +: 32]),
            .stable_word (in_stable[g]),
            .rise        (in_rise[g])
        );
    end

    // Read mux sees pre-update register state, so a read returns the value
    // as of its own request cycle.
    always_comb begin
        rd_data = UNMAPPED_DATA;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mmio_hit(req_word, MMIO_OUT_BASE, i)) rd_data = out_q[i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (mmio_hit(req_word, MMIO_IN_BASE, i))   rd_data = in_stable[i];
            if (mmio_hit(req_word, MMIO_EDGE_BASE, i)) rd_data = edge_q[i];
            if (mmio_hit(req_word, MMIO_MASK_BASE, i)) rd_data = mask_q[i];
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (req_wr && mmio_hit(req_word, MMIO_OUT_BASE, i)) begin
                    out_q[i] <= F2C_ReqDataQ502H;
                end
            end
        end
    end

    // W1C clear is applied before OR-ing in new rises, so a coincident rise survives.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            for (int i = 0; i < NUM_IN; i++) begin
                edge_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (req_wr && mmio_hit(req_word, MMIO_EDGE_BASE, i)) begin
                    edge_q[i] <= (edge_q[i] & ~F2C_ReqDataQ502H) | in_rise[i];
                end else begin
                    edge_q[i] <= edge_q[i] | in_rise[i];
                end
                if (req_wr && mmio_hit(req_word, MMIO_MASK_BASE, i)) begin
                    mask_q[i] <= F2C_ReqDataQ502H;
                end
            end
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            rsp_vld_q  <= 1'b0;
            rsp_op_q   <= RD;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= req_rd || req_wr;
            if (req_rd || req_wr) begin
                rsp_op_q   <= req_rd ? RD_RSP : WR_RSP;
                rsp_addr_q <= F2C_ReqAddressQ502H;
                rsp_data_q <= req_rd ? rd_data : F2C_ReqDataQ502H;
            end
        end
    end

    always_comb begin
        irq_any = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            irq_any = irq_any | (|(edge_q[i] & mask_q[i]));
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign OutRegs[32*g +: 32] = out_q[g];
    end

    assign IrqPending          = irq_any;
    assign F2C_RspValidQ500H   = rsp_vld_q;
    assign F2C_RspOpcodeQ500H  = rsp_op_q;
    assign F2C_RspAddressQ500H = rsp_addr_q;
    assign F2C_RspDataQ500H    = rsp_data_q;

endmodule

// File: tb/tb_mmio_io_bank.sv
// Randomised scoreboard bench for mmio_io_bank against an address-map reference model.
module tb_mmio_io_bank;
    import lotr_pkg::*;

    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 8;
    localparam int SYNC    = 2;
    localparam int DEB     = 16;

    typedef struct {
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk;
        int          due;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  req_vld;
    t_opcode               req_op;
    logic [31:0]           req_addr;
    logic [31:0]           req_data;
    logic                  rsp_vld;
    t_opcode               rsp_op;
    logic [31:0]           rsp_addr;
    logic [31:0]           rsp_data;
    logic [32*NUM_IN-1:0]  pins;
    logic [32*NUM_OUT-1:0] out_regs;
    logic                  irq;

    exp_t        sb_q [$];
    logic [31:0] cal_q [$];
    logic [31:0] out_m  [NUM_OUT];
    logic [31:0] in_m   [NUM_IN];
    logic [31:0] edge_m [NUM_IN];
    logic [31:0] mask_m [NUM_IN];
    int          n_cmp;
    int          n_bad;
    int          cyc;

    mmio_io_bank #(
        .NUM_IN          (NUM_IN),
        .NUM_OUT         (NUM_OUT),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .UNMAPPED_DATA   (32'hDEAD_BEEF)
    ) dut (
        .QClk                (clk),
        .RstQnnnH            (rst),
        .F2C_ReqValidQ502H   (req_vld),
        .F2C_ReqOpcodeQ502H  (req_op),
        .F2C_ReqAddressQ502H (req_addr),
        .F2C_ReqDataQ502H    (req_data),
        .F2C_RspValidQ500H   (rsp_vld),
        .F2C_RspOpcodeQ500H  (rsp_op),
        .F2C_RspAddressQ500H (rsp_addr),
        .F2C_RspDataQ500H    (rsp_data),
        .InPins              (pins),
        .OutRegs             (out_regs),
        .IrqPending          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte address [11:2] selects a word; each region is an array.
    task automatic model_reset();
        for (int i = 0; i < NUM_OUT; i++) out_m[i] = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_m[i] = '0; edge_m[i] = '0; mask_m[i] = '0;
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int w;
        w = int'(a[11:2]);
        if (w < NUM_OUT) return out_m[w];
        if (w >= 256 && w < 256 + NUM_IN) return in_m[w-256];
        if (w >= 384 && w < 384 + NUM_IN) return edge_m[w-384];
        if (w >= 448 && w < 448 + NUM_IN) return mask_m[w-448];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        int w;
        w = int'(a[11:2]);
        if (w < NUM_OUT) out_m[w] = d;
        else if (w >= 384 && w < 384 + NUM_IN) edge_m[w-384] = edge_m[w-384] & ~d;
        else if (w >= 448 && w < 448 + NUM_IN) mask_m[w-448] = d;
    endtask

    function automatic bit model_irq();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NUM_IN; i++) r = r | (|(edge_m[i] & mask_m[i]));
        return r;
    endfunction

    task automatic issue(input t_opcode op, input logic [31:0] a, input logic [31:0] d, input bit chk);
        exp_t e;
        req_vld = 1'b1; req_op = op; req_addr = a; req_data = d;
        e.addr = a; e.chk = chk; e.due = cyc + 1;
        if (op == RD) begin
            e.op = RD_RSP; e.data = model_rd(a);
            sb_q.push_back(e);
        end else if (op == WR) begin
            e.op = WR_RSP; e.data = d;
            sb_q.push_back(e);
            model_wr(a, d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic check_irq();
        check("irq_pending", 32'(irq), 32'(model_irq()));
    endtask

    task automatic check_outs();
        for (int i = 0; i < NUM_OUT; i++) check("out_regs", out_regs[32*i +: 32], out_m[i]);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [9:0] w;
        case ($urandom_range(0, 4))
            0:       w = 10'($urandom_range(0, NUM_OUT));
            1:       w = 10'(256 + $urandom_range(0, NUM_IN));
            2:       w = 10'(384 + $urandom_range(0, NUM_IN));
            3:       w = 10'(448 + $urandom_range(0, NUM_IN));
            default: w = 10'($urandom);
        endcase
        return {($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'h0, w, 2'($urandom)};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                    e = sb_q.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL missing_rsp: none for addr %h, expected at cycle %0d", e.addr, e.due);
                end
                if (rsp_vld) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_rsp: got addr %h data %h, expected no response", rsp_addr, rsp_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_latency", 32'(cyc), 32'(e.due));
                        check("rsp_opcode", 32'(rsp_op), 32'(e.op));
                        check("rsp_addr", rsp_addr, e.addr);
                        if (e.chk) check("rsp_data", rsp_data, e.data);
                        else cal_q.push_back(rsp_data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kfirst;
        int r;
        t_opcode op;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; req_vld = 1'b0; req_op = RD; req_addr = '0; req_data = '0; pins = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_vld", 32'(rsp_vld), 32'd0);
        check_outs();
        check_irq();
        rst = 1'b0;
        step();

        // Reset readback of each region
        issue(RD, 32'h000, 0, 1); step();
        issue(RD, 32'h400, 0, 1); step();
        issue(RD, 32'h600, 0, 1); step();
        issue(RD, 32'h700, 0, 1); step();

        // Write then read-back next cycle
        issue(WR, 32'h004, 32'hA5A5_0F0F, 1); step();
        issue(RD, 32'h004, 0, 1); step();
        check("out_word1", out_regs[63:32], 32'hA5A5_0F0F);

        // Debounce latency: poll IN[0] every cycle while bit 4 rises
        cal_q.delete();
        pins[4] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            issue(RD, 32'h400, 0, 0); step();
        end
        repeat (3) step();
        check("cal_count", 32'(cal_q.size()), 32'd40);
        kfirst = -1;
        for (int k = 0; k < cal_q.size(); k++) begin
            if (kfirst < 0 && cal_q[k] == 32'h10) kfirst = k;
        end
        check("debounce_window", 32'((kfirst >= SYNC + DEB) && (kfirst <= SYNC + DEB + 3)), 32'd1);
        if (kfirst < 0) kfirst = SYNC + DEB + 2;
        in_m[0] = 32'h10; edge_m[0] = edge_m[0] | 32'h10;
        issue(RD, 32'h600, 0, 1); step();
        issue(WR, 32'h600, 32'h10, 1); step();

        // Short glitch must be filtered out
        pins[0] = 1'b1;
        repeat (5) step();
        pins[0] = 1'b0;
        repeat (40) step();
        issue(RD, 32'h400, 0, 1); step();

        // Rise on bit 3, mask it, then W1C
        pins[3] = 1'b1;
        repeat (40) step();
        in_m[0] = 32'h18; edge_m[0] = edge_m[0] | 32'h08;
        issue(RD, 32'h600, 0, 1); step();
        check_irq();
        issue(WR, 32'h700, 32'h8, 1); step();
        check_irq();
        issue(WR, 32'h600, 32'h8, 1); step();
        check_irq();
        issue(RD, 32'h600, 0, 1); step();

        // Rise on bit 2 lands in the same cycle as a W1C of bit 2: set wins
        pins[2] = 1'b1;
        for (int k = 0; k < kfirst; k++) begin
            if (k == kfirst - 1) issue(WR, 32'h600, 32'h4, 1);
            step();
        end
        repeat (40) step();
        in_m[0] = 32'h1C; edge_m[0] = edge_m[0] | 32'h04;
        issue(RD, 32'h600, 0, 1); step();
        issue(WR, 32'h700, 32'h4, 1); step();
        check_irq();

        // Unmapped and read-only accesses
        issue(RD, 32'h7FC, 0, 1); step();
        issue(WR, 32'h400, 32'hFFFF_FFFF, 1); step();
        issue(RD, 32'h400, 0, 1); step();
        issue(RD, 32'h020, 0, 1); step();
        issue(RD, 32'h408, 0, 1); step();
        issue(RD, 32'h608, 0, 1); step();
        issue(RD, 32'h708, 0, 1); step();
        issue(RD, 32'hFFFF_F004, 0, 1); step();
        issue(RD_RSP, 32'h004, 0, 1); step();

        // Randomised traffic with pins held stable
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                step();
            end else begin
                op = (r < 5) ? RD : (r < 9) ? WR : (($urandom_range(0, 1) == 1) ? RD_RSP : WR_RSP);
                issue(op, rand_addr(), $urandom, 1);
                step();
                check_irq();
            end
            if (n % 50 == 49) check_outs();
        end

        // Drop pins: falls never set EDGE
        pins = '0;
        repeat (40) step();
        in_m[0] = '0;
        issue(RD, 32'h400, 0, 1); step();
        issue(RD, 32'h600, 0, 1); step();

        // Back-to-back burst, then reset while a response is in flight
        issue(WR, 32'h000, 32'h1111_2222, 1); step();
        issue(WR, 32'h008, 32'h3333_4444, 1); step();
        issue(RD, 32'h000, 0, 1); step();
        issue(RD, 32'h008, 0, 1); step();
        issue(RD, 32'h004, 0, 1); step();
        issue(WR, 32'h00C, 32'h5555_6666, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        req_vld = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outs();
        check_irq();
        for (int i = 0; i <= NUM_OUT; i++) begin
            issue(RD, 32'(4 * i), 0, 1); step();
        end
        for (int i = 0; i < NUM_IN; i++) begin
            issue(RD, 32'h400 + 32'(4 * i), 0, 1); step();
            issue(RD, 32'h600 + 32'(4 * i), 0, 1); step();
            issue(RD, 32'h700 + 32'(4 * i), 0, 1); step();
        end

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
